// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - LC-3 memory sequencer: SRAM read/write cycles with wait states and memory-mapped I/O
module mem_access_ctrl #(
    parameter int          WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [19:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] switches,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] mem_rdata,
    output logic        R,
    output logic        busy,
    output logic [15:0] hex_out,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int WS = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
    localparam int CW = (WS > 1) ? $clog2(WS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          accept;
    logic          is_io;

    assign accept = (state == IDLE) && (req_rd || req_wr);
    assign is_io  = (mem_address == IO_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Strobes decode from the state register alone, so an async reset releases them at once.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        R          = 1'b0;
        busy       = (state != IDLE);
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_io) begin
                        state_nx = DONE;
                    end else if (req_wr) begin
                        state_nx = WR_SETUP;
                    end else begin
                        state_nx = RD_ACCESS;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            RD_ACCESS: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (cnt == '0) state_nx = DONE;
                else           cnt_nx   = cnt - 1'b1;
            end
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_nx   = WR_PULSE;
                cnt_nx     = CNT_LOAD;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (cnt == '0) state_nx = WR_HOLD;
                else           cnt_nx   = cnt - 1'b1;
            end
            WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_dq_oe = 1'b1;
                state_nx   = DONE;
            end
            DONE: begin
                R        = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata   <= '0;
            hex_out     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            if (accept) begin
                sram_addr   <= mem_address;
                sram_dq_out <= mem_wdata;
                if (is_io) begin
                    if (req_wr) hex_out   <= mem_wdata;
                    else        mem_rdata <= switches;
                end
            end
            if (state == RD_ACCESS && cnt == '0) mem_rdata <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized and directed bench for mem_access_ctrl against a phase-timeline model
module tb_mem_access_ctrl;

    localparam int          WS      = 2;
    localparam logic [19:0] IO_ADDR = 20'h0FFFF;

    localparam int PH_IDLE = 0;
    localparam int PH_RD   = 1;
    localparam int PH_SET  = 2;
    localparam int PH_PUL  = 3;
    localparam int PH_HLD  = 4;
    localparam int PH_DONE = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_rd, req_wr;
    logic [19:0] mem_address;
    logic [15:0] mem_wdata, switches, sram_dq_in;
    logic [15:0] mem_rdata, hex_out, sram_dq_out;
    logic [19:0] sram_addr;
    logic        R, busy, sram_dq_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_tests = 0;
    int n_fail  = 0;

    int          exp_q[$];
    logic [15:0] exp_rdata, exp_hex, exp_dq;
    logic [19:0] exp_addr;

    int cyc, oe_lo, we_lo, ce_lo, dqoe_cnt, dq_ok, r_cnt, first_r;

    mem_access_ctrl #(.WAIT_STATES(WS), .IO_ADDR(IO_ADDR)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .switches(switches),
        .sram_dq_in(sram_dq_in), .mem_rdata(mem_rdata), .R(R), .busy(busy),
        .hex_out(hex_out), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_rdata = '0;
        exp_hex   = '0;
        exp_dq    = '0;
        exp_addr  = '0;
    endtask

    // An accepted access becomes a list of per-cycle phases; each clock consumes one.
    task automatic model_update(input logic rd, input logic wr, input logic [19:0] a,
                                input logic [15:0] wd, input logic [15:0] sw, input logic [15:0] dq);
        int ph;
        if (exp_q.size() == 0) begin
            if (rd || wr) begin
                exp_addr = a;
                exp_dq   = wd;
                if (a == IO_ADDR) begin
                    if (wr) exp_hex   = wd;
                    else    exp_rdata = sw;
                    exp_q.push_back(PH_DONE);
                end else if (wr) begin
                    exp_q.push_back(PH_SET);
                    for (int i = 0; i < WS; i++) exp_q.push_back(PH_PUL);
                    exp_q.push_back(PH_HLD);
                    exp_q.push_back(PH_DONE);
                end else begin
                    for (int i = 0; i < WS; i++) exp_q.push_back(PH_RD);
                    exp_q.push_back(PH_DONE);
                end
            end
        end else begin
            ph = exp_q.pop_front();
            if (ph == PH_RD && (exp_q.size() == 0 || exp_q[0] != PH_RD)) exp_rdata = dq;
        end
    endtask

    task automatic check_all();
        int   cur;
        logic idle_like;
        cur = (exp_q.size() != 0) ? exp_q[0] : PH_IDLE;
        idle_like = (cur == PH_IDLE) || (cur == PH_DONE);
        chk("ctrl{R,busy,ce,oe,we,ub,lb,dq_oe}",
            {24'd0, R, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe},
            {24'd0, cur == PH_DONE, cur != PH_IDLE, idle_like, cur != PH_RD, cur != PH_PUL,
             idle_like, idle_like, (cur == PH_SET) || (cur == PH_PUL) || (cur == PH_HLD)});
        chk("mem_rdata", {16'd0, mem_rdata}, {16'd0, exp_rdata});
        chk("hex_out", {16'd0, hex_out}, {16'd0, exp_hex});
        chk("sram_addr", {12'd0, sram_addr}, {12'd0, exp_addr});
        chk("sram_dq_out", {16'd0, sram_dq_out}, {16'd0, exp_dq});
    endtask

    task automatic clr_cnt();
        cyc = 0; oe_lo = 0; we_lo = 0; ce_lo = 0; dqoe_cnt = 0; dq_ok = 0; r_cnt = 0; first_r = 0;
    endtask

    // Entered at a falling edge; drives one cycle of inputs and checks the next cycle.
    task automatic step(input logic rd, input logic wr, input logic [19:0] a,
                        input logic [15:0] wd, input logic [15:0] sw, input logic [15:0] dq);
        req_rd = rd; req_wr = wr; mem_address = a; mem_wdata = wd; switches = sw; sram_dq_in = dq;
        model_update(rd, wr, a, wd, sw, dq);
        @(negedge clk);
        check_all();
        cyc++;
        if (!sram_oe_n) oe_lo++;
        if (!sram_we_n) we_lo++;
        if (!sram_ce_n) ce_lo++;
        if (sram_dq_oe) dqoe_cnt++;
        if (sram_dq_oe && sram_dq_out == 16'h1234) dq_ok++;
        if (R) begin
            r_cnt++;
            if (first_r == 0) first_r = cyc;
        end
    endtask

    task automatic idle_steps(input int n, input logic [15:0] dq);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 20'h0, 16'h0, 16'h0, dq);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_strobes"}, {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk({tag, "_r_busy_oe"}, {29'd0, R, busy, sram_dq_oe}, 32'h0);
        chk({tag, "_rdata"}, {16'd0, mem_rdata}, 32'h0);
        chk({tag, "_hex"}, {16'd0, hex_out}, 32'h0);
        chk({tag, "_addr"}, {12'd0, sram_addr}, 32'h0);
        chk({tag, "_dq_out"}, {16'd0, sram_dq_out}, 32'h0);
    endtask

    task automatic mid_reset(input string tag);
        req_rd = 1'b0; req_wr = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values(tag);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
        mem_address = '0; mem_wdata = '0; switches = '0; sram_dq_in = '0;
        model_clear();
        #2 check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;
        check_all();

        clr_cnt();
        step(1'b1, 1'b0, 20'h00123, 16'h0, 16'h0, 16'hBEEF);
        idle_steps(4, 16'hBEEF);
        chk("rd_oe_low_cycles", oe_lo, 2);
        chk("rd_r_count", r_cnt, 1);
        chk("rd_r_cycle", first_r, 3);
        chk("rd_data", {16'd0, mem_rdata}, 32'hBEEF);

        clr_cnt();
        step(1'b0, 1'b1, 20'h00040, 16'h1234, 16'h0, 16'h0);
        idle_steps(6, 16'h0);
        chk("wr_we_low_cycles", we_lo, 2);
        chk("wr_dq_oe_cycles", dqoe_cnt, 4);
        chk("wr_dq_out_cycles", dq_ok, 4);
        chk("wr_oe_low_cycles", oe_lo, 0);
        chk("wr_r_cycle", first_r, 5);
        chk("wr_rdata_held", {16'd0, mem_rdata}, 32'hBEEF);

        clr_cnt();
        step(1'b0, 1'b1, IO_ADDR, 16'hABCD, 16'h0, 16'h0);
        chk("io_wr_hex", {16'd0, hex_out}, 32'hABCD);
        idle_steps(2, 16'h0);
        chk("io_wr_r_cycle", first_r, 1);
        chk("io_wr_ce_low", ce_lo, 0);

        clr_cnt();
        step(1'b1, 1'b0, IO_ADDR, 16'h0, 16'h5A5A, 16'h0);
        chk("io_rd_data", {16'd0, mem_rdata}, 32'h5A5A);
        idle_steps(2, 16'h0);
        chk("io_rd_oe_low", oe_lo, 0);

        clr_cnt();
        step(1'b1, 1'b1, 20'h00010, 16'h7777, 16'h0, 16'hFFFF);
        idle_steps(6, 16'hFFFF);
        chk("both_we_low_cycles", we_lo, 2);
        chk("both_oe_low_cycles", oe_lo, 0);
        chk("both_rdata_kept", {16'd0, mem_rdata}, 32'h5A5A);

        clr_cnt();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 20'h00200, 16'h0, 16'h0, 16'h1111);
        chk("held_first_rdata", {16'd0, mem_rdata}, 32'h1111);
        chk("held_r_count", r_cnt, 1);
        chk("held_second_rd_oe", {31'd0, sram_oe_n}, 32'h0);
        mid_reset("midrst");
        clr_cnt();
        idle_steps(6, 16'h2222);
        chk("no_r_after_reset", r_cnt, 0);

        for (int i = 0; i < 600; i++) begin
            logic        rd, wr;
            logic [19:0] a;
            rd = ($urandom_range(0, 9) < 3);
            wr = ($urandom_range(0, 9) < 3);
            a  = ($urandom_range(0, 3) == 0) ? IO_ADDR : 20'($urandom);
            step(rd, wr, a, 16'($urandom), 16'($urandom), 16'($urandom));
            if (i == 300) mid_reset("randrst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
